// File: rtl/out_port_uart_tx_pkg.sv
// Shared definitions for the output-port UART transmitter: serializer
// state encodings and framing constants.
package out_port_uart_tx_pkg;

  typedef enum logic [1:0] {
    S_Idle  = 2'b00,
    S_Start = 2'b01,
    S_Data  = 2'b10,
    S_Stop  = 2'b11
  } uart_state_e;

  localparam int unsigned BITS_PER_BYTE = 8;

endpackage

// File: rtl/out_port_uart_tx_sync_fifo.sv
// Small synchronous word FIFO. Pointers wrap modulo depth; a push while full
// is ignored (the caller flags the overflow), a pop while empty is ignored.
module sync_fifo #(
  parameter int unsigned DataWidth = 16,
  parameter int unsigned AddrBits  = 2
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 push,
  input  logic                 pop,
  input  logic [DataWidth-1:0] din,
  output logic [DataWidth-1:0] dout,
  output logic                 full,
  output logic                 empty
);

  localparam int unsigned Depth = 1 << AddrBits;

  logic [DataWidth-1:0] mem_q [Depth];
  logic [AddrBits-1:0]  wr_ptr_q, rd_ptr_q;
  logic [AddrBits:0]    count_q;
  logic                 do_push, do_pop;

  // Full/empty come from the registered count, so acceptance uses the pre-edge count.
  assign full    = (count_q == (AddrBits + 1)'(Depth));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem_q[rd_ptr_q];

  // Storage array; contents need no reset since count gates every read.
  always_ff @(posedge Clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  // Pointer and occupancy bookkeeping; pointer width gives the modulo wrap.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/out_port_uart_tx.sv
// Output-port UART transmitter: queues CPU output-register writes and sends
// each word as DataWidth/8 bytes, low byte first, 8N1, LSB first.
module out_port_uart_tx
  import out_port_uart_tx_pkg::*;
#(
  parameter int unsigned DataWidth    = 16,
  parameter int unsigned ClkDiv       = 4,
  parameter int unsigned FifoAddrBits = 2
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Wr,
  input  logic [DataWidth-1:0] Data_in,
  output logic                 Full,
  output logic                 Busy,
  output logic                 Overflow,
  output logic                 Tx
);

  localparam int unsigned NumBytes = DataWidth / BITS_PER_BYTE;
  localparam int unsigned ByteIdxW = (NumBytes > 1) ? $clog2(NumBytes) : 1;
  localparam int unsigned DivW     = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;

  localparam logic [DivW-1:0]     LastDiv  = DivW'(ClkDiv - 1);
  localparam logic [ByteIdxW-1:0] LastByte = ByteIdxW'(NumBytes - 1);
  localparam logic [2:0]          LastBit  = 3'(BITS_PER_BYTE - 1);

  uart_state_e          state_q, state_d;
  logic [DivW-1:0]      div_q, div_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [ByteIdxW-1:0]  byte_idx_q, byte_idx_d;
  logic [DataWidth-1:0] shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic                 overflow_q, overflow_d;
  logic                 div_last;

  logic                 fifo_pop;
  logic [DataWidth-1:0] fifo_dout;
  logic                 fifo_full, fifo_empty;

  sync_fifo #(
    .DataWidth (DataWidth),
    .AddrBits  (FifoAddrBits)
  ) u_fifo (
    .Clk   (Clk),
    .Reset (Reset),
    .push  (Wr),
    .pop   (fifo_pop),
    .din   (Data_in),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign div_last = (div_q == LastDiv);

  // Next-state logic: serializer FSM, bit timing and the line level for the next cycle.
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;
    fifo_pop   = 1'b0;
    tx_d       = 1'b1;
    overflow_d = overflow_q | (Wr & fifo_full);

    unique case (state_q)
      S_Idle: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          shift_d    = fifo_dout;
          byte_idx_d = '0;
          div_d      = '0;
          state_d    = S_Start;
        end
      end
      S_Start: begin
        tx_d = 1'b0;
        if (div_last) begin
          div_d     = '0;
          bit_idx_d = '0;
          state_d   = S_Data;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_Data: begin
        tx_d = shift_q[bit_idx_q];
        if (div_last) begin
          div_d = '0;
          if (bit_idx_q == LastBit) begin
            state_d = S_Stop;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_Stop: begin
        tx_d = 1'b1;
        if (div_last) begin
          div_d = '0;
          if (byte_idx_q != LastByte) begin
            byte_idx_d = byte_idx_q + 1'b1;
            shift_d    = shift_q >> BITS_PER_BYTE;
            state_d    = S_Start;
          end else begin
            state_d = S_Idle;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = S_Idle;
    endcase
  end

  // State registers; reset drops any frame in flight and returns the line high.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= S_Idle;
      div_q      <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      overflow_q <= overflow_d;
    end
  end

  assign Tx       = tx_q;
  assign Full     = fifo_full;
  assign Overflow = overflow_q;
  assign Busy     = ~fifo_empty | (state_q != S_Idle);

endmodule

// File: tb/tb_out_port_uart_tx.sv
// Bench for out_port_uart_tx at DataWidth=16, ClkDiv=4, depth 4.
module tb_out_port_uart_tx;

  logic        Clk;
  logic        Reset;
  logic        Wr;
  logic [15:0] Data_in;
  logic        Full, Busy, Overflow, Tx;

  int n_cmp  = 0;
  int n_fail = 0;

  out_port_uart_tx #(
    .DataWidth    (16),
    .ClkDiv       (4),
    .FifoAddrBits (2)
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Wr       (Wr),
    .Data_in  (Data_in),
    .Full     (Full),
    .Busy     (Busy),
    .Overflow (Overflow),
    .Tx       (Tx)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [15:0] data;
    logic [7:0]  lo;
    logic [7:0]  hi;
  } vec_t;

  vec_t       vecs [10];
  logic [7:0] rx_q [$];
  logic [7:0] exp_q [$];
  int         frame_err = 0;

  // Serial decoder: samples the line at negedge, mid-bit at offset 2 of each 4-cycle bit.
  initial begin
    int         cnt;
    logic       active;
    logic [7:0] rx_byte;
    active  = 1'b0;
    cnt     = 0;
    rx_byte = '0;
    forever begin
      @(negedge Clk);
      if (!Reset) begin
        active = 1'b0;
        cnt    = 0;
      end else if (!active) begin
        if (Tx == 1'b0) begin
          active = 1'b1;
          cnt    = 1;
        end
      end else begin
        if (cnt == 2 && Tx != 1'b0) begin
          frame_err++;
          active = 1'b0;
        end else if (cnt == 38) begin
          if (Tx != 1'b1) frame_err++;
          else rx_q.push_back(rx_byte);
          active = 1'b0;
        end else if ((cnt % 4) == 2 && cnt >= 6 && cnt <= 34) begin
          rx_byte[cnt / 4 - 1] = Tx;
        end
        cnt++;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic push(input logic [15:0] d);
    Wr      = 1'b1;
    Data_in = d;
    tick();
    Wr      = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int bound);
    int n;
    n = 0;
    while (Busy && n < bound) begin
      tick();
      n++;
    end
    check(name, Busy, 0);
    repeat (3) tick();
  endtask

  task automatic compare_rx(input string name);
    check({name, "_len"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      check($sformatf("%s_byte%0d", name, i), rx_q[i], exp_q[i]);
    end
    rx_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic       bits_1234 [20];
    logic [5:0] d_full, d_ovf;
    logic       full_seen;

    vecs[0] = '{16'h0001, 8'h01, 8'h00};
    vecs[1] = '{16'h0002, 8'h02, 8'h00};
    vecs[2] = '{16'h0003, 8'h03, 8'h00};
    vecs[3] = '{16'h0004, 8'h04, 8'h00};
    vecs[4] = '{16'h0005, 8'h05, 8'h00};
    vecs[5] = '{16'hBEEF, 8'hEF, 8'hBE};
    vecs[6] = '{16'h55AA, 8'hAA, 8'h55};
    vecs[7] = '{16'h8001, 8'h01, 8'h80};
    vecs[8] = '{16'h7E3C, 8'h3C, 8'h7E};
    vecs[9] = '{16'hC3F0, 8'hF0, 8'hC3};

    // Line pattern for 0x1234: start, 0x34 LSB first, stop, start, 0x12, stop.
    bits_1234 = '{0, 0,0,1,0,1,1,0,0, 1, 0, 0,1,0,0,1,0,0,0, 1};
    d_full    = 6'b111000;  // bit i = Full after Wr i (mid-frame burst)
    d_ovf     = 6'b110000;

    Reset   = 1'b0;
    Wr      = 1'b0;
    Data_in = '0;
    repeat (3) tick();
    Reset = 1'b1;

    // Idle after reset
    for (int i = 0; i < 50; i++) begin
      tick();
      check("idle_outputs", {Tx, Busy, Full, Overflow}, 4'b1000);
    end

    // Single word 0x1234: exact line waveform
    push(16'h1234);
    check("single_busy", Busy, 1);
    tick();
    check("single_pre_start", Tx, 1);
    for (int n = 0; n < 80; n++) begin
      tick();
      check($sformatf("single_tx_c%0d", n), Tx, bits_1234[n / 4]);
    end
    check("single_busy_done", Busy, 0);
    check("single_tx_done", Tx, 1);
    repeat (3) tick();
    exp_q = '{8'h12};
    exp_q.push_front(8'h34);
    compare_rx("single_rx");

    // Five back-to-back writes: first word popped, so all five fit
    for (int i = 0; i < 5; i++) begin
      push(vecs[i].data);
      check($sformatf("five_full%0d", i), Full, (i == 4) ? 1 : 0);
    end
    check("five_ovf", Overflow, 0);
    wait_idle("five_drain", 1000);
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(vecs[i].lo);
      exp_q.push_back(vecs[i].hi);
    end
    compare_rx("five_rx");
    check("five_ovf_end", Overflow, 0);

    // Burst of six while a frame is in progress: no pops, so writes 5 and 6 drop
    push(16'h1111);
    repeat (10) tick();
    for (int i = 0; i < 6; i++) begin
      push(16'h2001 + 16'(i));
      check($sformatf("burst_full%0d", i), Full, d_full[i]);
      check($sformatf("burst_ovf%0d", i), Overflow, d_ovf[i]);
    end
    wait_idle("burst_drain", 1000);
    check("burst_ovf_sticky", Overflow, 1);
    exp_q = '{8'h11, 8'h11, 8'h01, 8'h20, 8'h02, 8'h20, 8'h03, 8'h20, 8'h04, 8'h20};
    compare_rx("burst_rx");

    // Reset during data bits of 0xA5A5 with a second word queued
    push(16'hA5A5);
    push(16'h5A5A);
    repeat (14) tick();
    Reset = 1'b0;
    #1;
    check("rst_tx", Tx, 1);
    check("rst_busy", Busy, 0);
    check("rst_full", Full, 0);
    check("rst_ovf", Overflow, 0);
    tick();
    tick();
    Reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("post_rst_idle", {Tx, Busy}, 2'b10);
    end
    compare_rx("rst_partial_rx");
    push(16'h00FF);
    wait_idle("post_rst_drain", 500);
    exp_q = '{8'hFF, 8'h00};
    compare_rx("post_rst_rx");

    // Ten words, paced so the FIFO never fills, across pointer wrap
    full_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      push(vecs[i].data);
      full_seen |= Full;
      for (int j = 0; j < 69; j++) begin
        tick();
        full_seen |= Full;
      end
    end
    wait_idle("wrap_drain", 1000);
    check("wrap_never_full", full_seen, 0);
    check("wrap_ovf", Overflow, 0);
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(vecs[i].lo);
      exp_q.push_back(vecs[i].hi);
    end
    compare_rx("wrap_rx");

    check("frame_errors", frame_err, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "bench timeout");
  end

endmodule
